ps2_frame_receiver: RTL and testbench
=====================================

# ps2_frame_receiver

Deserialises the PS/2 device-to-host serial stream into 8-bit scan-code bytes for the keyboard controller's keycode logic. It sits directly upstream of the scan-code converter. It synchronises and glitch-filters the raw device clock and data lines, frames 11-bit packets, and checks start, parity and stop bits. It aborts stalled frames on a peripheral-clock-based timeout and reports each byte or error as a single-cycle pulse.

## Interface
- `over_time`, 16'd1000: number of `peripheral_clock` rising edges without a device-clock falling edge, mid-frame, before the frame is aborted.
- `filter_depth`, 4'd8: number of consecutive identical synchronised samples required before a filtered line changes state. Legal range is 2..15.

Ports:
- `clock`, in, 1: the single system clock. All logic is clocked on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `peripheral_clock`, in, 1: slow timebase. It is sampled as data and is not used as a clock.
- `device_clock`, in, 1: raw PS/2 clock line, asynchronous to `clock`.
- `device_data`, in, 1: raw PS/2 data line, asynchronous to `clock`.
- `register`, out, 8: last correctly received data byte. It holds its value between frames.
- `recieved_flag`, out, 1: one-cycle pulse. When it is high, `register` is valid with the new byte.
- `error_flag`, out, 1: one-cycle pulse indicating a framing, parity or timeout error.

## Operation
- **Input conditioning.**
  - Each of `device_clock`, `device_data` and `peripheral_clock` passes through a 2-FF synchroniser.
  - `device_clock` and `device_data` then pass through a `filter_depth` glitch filter. The filtered output changes only after `filter_depth` consecutive equal samples.
  - Filtered outputs reset to 1. The synchronised `peripheral_clock` resets to 0.
- **Strobe generation.**
  - A bit strobe is the filtered device clock going from 1 to 0.
  - A tick is the synchronised `peripheral_clock` going from 0 to 1.
- **State machine.** States are IDLE, RECV and CHECK.
  - IDLE: on a strobe with filtered data = 0, go to RECV and set bit count = 1. On a strobe with data = 1, ignore it and stay in IDLE with no error.
  - RECV: on each strobe, shift the data bit in, LSB first. Bits 1..8 are data, bit 9 is parity and bit 10 is stop. After the stop bit, go to CHECK.
  - CHECK: lasts one cycle. If the stop bit = 1 and XOR(data[7:0], parity) = 1 (odd parity), load `register` and pulse `recieved_flag`. Otherwise pulse `error_flag` and leave `register` unchanged. Return to IDLE.
- **Timeout.**
  - A 16-bit counter increments on each tick while in RECV. It clears on every strobe and on leaving RECV.
  - When the counter reaches `over_time`, pulse `error_flag` and go to IDLE. Partial data is discarded.
  - In IDLE the counter is held at 0.
- **Simultaneous events.**
  - A strobe and a timeout in the same cycle: the strobe wins and the counter clears.
  - `recieved_flag` and `error_flag` are never high together.
- **Reset mid-frame.** The receiver returns to IDLE and the partial frame is lost. No flag is generated.

## Timing
- Reset values: `register` = 8'h00, `recieved_flag` = 0, `error_flag` = 0. The state is IDLE and the counters are 0.
- Strobe latency: the strobe is asserted 2 (synchroniser) + `filter_depth` + 1 (edge register) `clock` cycles after the raw falling edge.
- Flag latency: the flag goes high in the cycle after the stop-bit strobe (the CHECK cycle) and is high for exactly 1 cycle.
- `register` updates in the same cycle that `recieved_flag` rises. It is stable thereafter until the next good frame.
- There is no back-pressure. The consumer must accept each pulse. The next frame can start in the cycle after CHECK.
- Timeout resolution is ±1 tick plus 3 `clock` cycles.

## Structure
- Shared package `ps2_pkg`:
  - the state enum (IDLE, RECV, CHECK);
  - constant `PS2_FRAME_BITS` = 11;
  - constants `PS2_PARITY_BIT` = 9 and `PS2_STOP_BIT` = 10.
- One sub-module, `ps2_line_filter`, parameterised by `filter_depth`. It contains the 2-FF synchroniser and the stability filter. It is instantiated twice, once for clock and once for data.
- Top level: edge detectors, FSM, bit counter, shift register, timeout counter and output flags.

## Test plan
- **Valid frame.** Send byte 0x1C with parity 0 and stop 1 → `register` = 8'h1C and `recieved_flag` high for 1 cycle. `error_flag` stays 0.
- **Back-to-back frames.** Send 0xF0 (parity 1), then immediately 0x1C → two `recieved_flag` pulses, with `register` = F0 then 1C.
- **Bad parity and bad stop.**
  - Send 0x1C with parity 1 → `error_flag` pulses and `register` keeps its prior value.
  - Send 0x1C with stop = 0 → same response.
- **Timeout.** Send 5 bits, then stop clocking for `over_time` + 2 ticks → one `error_flag` pulse and the FSM returns to IDLE. A following valid 0x1C frame is received correctly.
- **Glitch rejection.** Apply a device-clock low pulse of `filter_depth` − 2 cycles while idle and during a frame → no strobe, no flag, and the frame still decodes correctly.
- **Reset mid-frame.** Assert `reset` after bit 6 → all outputs and `register` are 0 with no flag. A subsequent full 0x1C frame is received.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 device-to-host receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StCheck
  } ps2_state_e;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_PARITY_BIT = 9;
  localparam int unsigned PS2_STOP_BIT   = 10;

  // bits[i] holds frame bit i+1: data in [7:0], parity in [8], stop in [9].
  function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-2:0] bits);
    return bits[PS2_STOP_BIT-1] & (^bits[PS2_PARITY_BIT-1:0]);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser followed by a stability filter for one idle-high PS/2 line.
module ps2_line_filter #(
  parameter int unsigned filter_depth = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic filt_o
);

  localparam logic [3:0] LastCnt = 4'(filter_depth - 1);

  logic [1:0] sync_q;
  logic [3:0] cnt_q, cnt_d;
  logic       filt_q, filt_d;

  // Count consecutive samples that disagree with the filtered level; flip on the last one.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_q[1] == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == LastCnt) begin
      filt_d = sync_q[1];
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Synchroniser and filter state; the line idles high so everything resets to 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: conditions the lines, frames 11-bit packets,
// checks start/parity/stop and reports each byte or error as a one-cycle pulse.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter logic [15:0] over_time    = 16'd1000,
  parameter int unsigned filter_depth = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       peripheral_clock,
  input  logic       device_clock,
  input  logic       device_data,
  output logic [7:0] register,
  output logic       recieved_flag,
  output logic       error_flag
);

  logic       dclk_filt, ddat_filt;
  logic       dclk_prev_q;
  logic [1:0] pclk_sync_q;
  logic       pclk_prev_q;
  logic       strobe, tick;

  ps2_state_e                  state_q;
  logic [3:0]                  bit_cnt_q;
  logic [PS2_FRAME_BITS-2:0]   shift_q;
  logic [PS2_FRAME_BITS-2:0]   frame;
  logic [15:0]                 tmo_q;

  ps2_line_filter #(
    .filter_depth(filter_depth)
  ) u_clk_filter (
    .clk_i (clock),
    .rst_i (reset),
    .line_i(device_clock),
    .filt_o(dclk_filt)
  );

  ps2_line_filter #(
    .filter_depth(filter_depth)
  ) u_data_filter (
    .clk_i (clock),
    .rst_i (reset),
    .line_i(device_data),
    .filt_o(ddat_filt)
  );

  // Edge registers for the filtered device clock and synchronised peripheral timebase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dclk_prev_q <= 1'b1;
      pclk_sync_q <= 2'b00;
      pclk_prev_q <= 1'b0;
    end else begin
      dclk_prev_q <= dclk_filt;
      pclk_sync_q <= {pclk_sync_q[0], peripheral_clock};
      pclk_prev_q <= pclk_sync_q[1];
    end
  end

  assign strobe = dclk_prev_q & ~dclk_filt;
  assign tick   = pclk_sync_q[1] & ~pclk_prev_q;

  // Completed frame as it will look once the stop bit currently on the line is shifted in.
  assign frame = {ddat_filt, shift_q[PS2_FRAME_BITS-2:1]};

  // Framing FSM with bit counter, shift register, timeout and registered outputs.
  // The verdict is registered on the stop-bit strobe so the flags are high during StCheck.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      tmo_q         <= '0;
      register      <= 8'h00;
      recieved_flag <= 1'b0;
      error_flag    <= 1'b0;
    end else begin
      recieved_flag <= 1'b0;
      error_flag    <= 1'b0;
      case (state_q)
        StIdle: begin
          tmo_q <= '0;
          // A strobe with data high is not a start bit and is silently ignored.
          if (strobe && !ddat_filt) begin
            state_q   <= StRecv;
            bit_cnt_q <= 4'd1;
          end
        end
        StRecv: begin
          if (strobe) begin
            // A strobe beats a coincident timeout.
            tmo_q   <= '0;
            shift_q <= frame;
            if (bit_cnt_q == 4'(PS2_STOP_BIT)) begin
              state_q <= StCheck;
              if (ps2_frame_ok(frame)) begin
                register      <= frame[7:0];
                recieved_flag <= 1'b1;
              end else begin
                error_flag <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else if (tmo_q == over_time) begin
            error_flag <= 1'b1;
            tmo_q      <= '0;
            state_q    <= StIdle;
          end else if (tick) begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        StCheck: begin
          tmo_q   <= '0;
          state_q <= StIdle;
        end
        default: begin
          tmo_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver: table vectors, corner sequences, random frames.
module tb_ps2_frame_receiver;

  localparam int unsigned FD      = 4;
  localparam logic [15:0] OT      = 16'd12;
  localparam int          HALF    = 30;  // device clock half period in system clocks
  localparam int          TICK_CY = 16;  // peripheral clock period in system clocks

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pclk = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic [7:0] reg_o;
  logic       rcv, errf;

  int checks = 0;
  int errors = 0;

  // Monitor state
  logic [7:0] rx_log[$];
  int         err_n = 0;
  logic       prev_rx = 1'b0, prev_err = 1'b0;
  logic       overlap_seen = 1'b0, wide_seen = 1'b0;

  logic [7:0] model_reg;

  typedef struct {
    string      name;
    logic [7:0] b;
    logic       par;
    logic       stop;
    int         exp_rx;
    int         exp_err;
    logic [7:0] exp_reg;
  } vec_t;
  vec_t tbl[9];

  ps2_frame_receiver #(
    .over_time   (OT),
    .filter_depth(FD)
  ) dut (
    .clock           (clk),
    .reset           (rst),
    .peripheral_clock(pclk),
    .device_clock    (dev_clk),
    .device_data     (dev_data),
    .register        (reg_o),
    .recieved_flag   (rcv),
    .error_flag      (errf)
  );

  always #5 clk = ~clk;
  always #(TICK_CY * 5) pclk = ~pclk;

  always @(negedge clk) begin
    prev_rx  <= rcv;
    prev_err <= errf;
    if (rcv) rx_log.push_back(reg_o);
    if (errf) err_n <= err_n + 1;
    if (rcv && errf) overlap_seen <= 1'b1;
    if ((rcv && prev_rx) || (errf && prev_err)) wide_seen <= 1'b1;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input logic par,
                                          input logic stop);
    return {stop, par, b, 1'b0};
  endfunction

  // Device side: data changes while the clock is high, host samples on the falling edge.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      dev_data = bits[i];
      cycles(HALF);
      if (i == glitch_bit) begin
        dev_clk = 1'b0;
        cycles(FD - 2);
        dev_clk = 1'b1;
        cycles(HALF);
      end
      dev_clk = 1'b0;
      cycles(HALF);
      dev_clk = 1'b1;
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] b, input logic par,
                           input logic stop, input int glitch_bit, input int exp_rx,
                           input int exp_err, input logic [7:0] exp_reg);
    int r0 = rx_log.size();
    int e0 = err_n;
    send_bits(mkframe(b, par, stop), 11, glitch_bit);
    cycles(HALF);
    check({name, " rx pulses"}, rx_log.size() - r0, exp_rx);
    check({name, " err pulses"}, err_n - e0, exp_err);
    check({name, " register"}, int'(reg_o), int'(exp_reg));
    if (exp_rx == 1 && rx_log.size() > r0)
      check({name, " register at pulse"}, int'(rx_log[r0]), int'(exp_reg));
  endtask

  initial begin
    int r0, e0;
    logic [7:0] b;
    logic par, stop, ok;

    tbl[0] = '{"good 1C",      8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
    tbl[1] = '{"good F0",      8'hF0, 1'b1, 1'b1, 1, 0, 8'hF0};
    tbl[2] = '{"bad parity",   8'h1C, 1'b1, 1'b1, 0, 1, 8'hF0};
    tbl[3] = '{"bad stop",     8'h1C, 1'b0, 1'b0, 0, 1, 8'hF0};
    tbl[4] = '{"good 00",      8'h00, 1'b1, 1'b1, 1, 0, 8'h00};
    tbl[5] = '{"good FF",      8'hFF, 1'b1, 1'b1, 1, 0, 8'hFF};
    tbl[6] = '{"bad parity FF", 8'hFF, 1'b0, 1'b1, 0, 1, 8'hFF};
    tbl[7] = '{"bad parity 55", 8'h55, 1'b0, 1'b1, 0, 1, 8'hFF};
    tbl[8] = '{"good A5",      8'hA5, 1'b1, 1'b1, 1, 0, 8'hA5};

    // Reset state
    cycles(3);
    check("reset register", int'(reg_o), 0);
    check("reset rx flag", int'(rcv), 0);
    check("reset err flag", int'(errf), 0);
    rst = 1'b0;
    cycles(20);

    foreach (tbl[i])
      run_frame(tbl[i].name, tbl[i].b, tbl[i].par, tbl[i].stop, -1, tbl[i].exp_rx,
                tbl[i].exp_err, tbl[i].exp_reg);

    // Back-to-back frames
    r0 = rx_log.size();
    e0 = err_n;
    send_bits(mkframe(8'hF0, 1'b1, 1'b1), 11, -1);
    send_bits(mkframe(8'h1C, 1'b0, 1'b1), 11, -1);
    cycles(HALF);
    check("b2b rx pulses", rx_log.size() - r0, 2);
    check("b2b err pulses", err_n - e0, 0);
    if (rx_log.size() >= r0 + 2) begin
      check("b2b first byte", int'(rx_log[r0]), 8'hF0);
      check("b2b second byte", int'(rx_log[r0+1]), 8'h1C);
    end

    // Timeout after 5 bits, then a clean frame
    r0 = rx_log.size();
    e0 = err_n;
    send_bits(mkframe(8'h1C, 1'b0, 1'b1), 5, -1);
    cycles((int'(OT) + 2) * TICK_CY);
    check("timeout err pulses", err_n - e0, 1);
    check("timeout rx pulses", rx_log.size() - r0, 0);
    check("timeout register", int'(reg_o), 8'h1C);
    run_frame("after timeout", 8'h1C, 1'b0, 1'b1, -1, 1, 0, 8'h1C);

    // Glitch while idle, with data low so a leaked strobe would start a frame and time out
    r0 = rx_log.size();
    e0 = err_n;
    dev_data = 1'b0;
    cycles(HALF);
    dev_clk = 1'b0;
    cycles(FD - 2);
    dev_clk = 1'b1;
    cycles((int'(OT) + 4) * TICK_CY);
    dev_data = 1'b1;
    check("idle glitch err pulses", err_n - e0, 0);
    check("idle glitch rx pulses", rx_log.size() - r0, 0);

    // Glitch during a frame
    run_frame("frame glitch", 8'hA5, 1'b1, 1'b1, 4, 1, 0, 8'hA5);

    // Reset after bit 6
    r0 = rx_log.size();
    e0 = err_n;
    send_bits(mkframe(8'h1C, 1'b0, 1'b1), 7, -1);
    rst = 1'b1;
    cycles(1);
    check("midreset register", int'(reg_o), 0);
    check("midreset rx flag", int'(rcv), 0);
    check("midreset err flag", int'(errf), 0);
    cycles(2);
    rst = 1'b0;
    cycles(20);
    check("midreset rx pulses", rx_log.size() - r0, 0);
    check("midreset err pulses", err_n - e0, 0);
    run_frame("after reset", 8'h1C, 1'b0, 1'b1, -1, 1, 0, 8'h1C);
    model_reg = 8'h1C;

    // Random frames against a reference model
    for (int n = 0; n < 20; n++) begin
      b    = 8'($urandom_range(0, 255));
      par  = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      ok   = stop && ((^b) ^ par);
      if (ok) model_reg = b;
      run_frame($sformatf("random %0d", n), b, par, stop, -1, ok ? 1 : 0, ok ? 0 : 1,
                model_reg);
    end

    check("flags never together", int'(overlap_seen), 0);
    check("flags single cycle", int'(wide_seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
